// File: rtl/ex_mem_branch_stage_pkg.sv
// ex_mem_branch_stage_pkg: branch condition encodings, squash FSM state type and default squash depth
package ex_mem_branch_stage_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } br_type_e;

    typedef enum logic {RUN, SQUASH} state_e;

    localparam int DEFAULT_SQUASH_DEPTH = 2;

endpackage

// File: rtl/ex_mem_branch_stage_branch_cond.sv
// branch_cond: decides branch taken from the A-B flags of the arithmetic unit
module branch_cond
    import ex_mem_branch_stage_pkg::*;
(
    input  logic [2:0] br_type,
    input  logic       C,
    input  logic       V,
    input  logic       N,
    input  logic       Z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = Z;
            BR_BNE:  taken = !Z;
            BR_BLT:  taken = N ^ V;
            BR_BGE:  taken = !(N ^ V);
            BR_BLTU: taken = !C;
            BR_BGEU: taken = C;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX/MEM register with branch resolution, redirect and wrong-path squash.
// Define BRANCH_STATS_EN to build the saturating branch/taken counters.
module ex_mem_branch_stage
    import ex_mem_branch_stage_pkg::*;
#(
    parameter int size         = 32,
    parameter int SQUASH_DEPTH = DEFAULT_SQUASH_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [size-1:0] S,
    input  logic            C,
    input  logic            V,
    input  logic            N,
    input  logic            Z,
    input  logic [size-1:0] pc,
    input  logic [size-1:0] imm,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [size-1:0] store_data,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      br_type,
    input  logic            flush,
    input  logic            out_ready,
    output logic            in_ready,
    output logic            out_valid,
    output logic [size-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [size-1:0] out_store_data,
    output logic            redirect,
    output logic [size-1:0] redirect_pc,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
);

    localparam int CW = SQUASH_DEPTH > 0 ? $clog2(SQUASH_DEPTH + 1) : 1;

    state_e          state, state_nx;
    logic [CW-1:0]   sq_cnt, sq_cnt_nx;
    logic            taken, accept, jump, xfer, live;

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign jump     = is_jal | is_jalr;
    assign xfer     = jump | (is_branch & taken);
    // an instruction that really executes: accepted, not on the wrong path, not flushed
    assign live     = accept & (state == RUN) & !flush;

    branch_cond u_cond (
        .br_type (br_type),
        .C       (C),
        .V       (V),
        .N       (N),
        .Z       (Z),
        .taken   (taken)
    );

    always_comb begin
        state_nx  = state;
        sq_cnt_nx = sq_cnt;
        if (flush) begin
            state_nx  = RUN;
            sq_cnt_nx = '0;
        end else if (live && xfer && SQUASH_DEPTH > 0) begin
            state_nx  = SQUASH;
            sq_cnt_nx = CW'(SQUASH_DEPTH);
        end else if (accept && state == SQUASH) begin
            sq_cnt_nx = sq_cnt - CW'(1);
            state_nx  = sq_cnt == CW'(1) ? RUN : SQUASH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nx;
            sq_cnt <= sq_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_store_data <= '0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect <= live & xfer;
            if (live & xfer)
                redirect_pc <= is_jalr ? {S[size-1:1], 1'b0} : pc + imm;
            if (flush)
                out_valid <= 1'b0;
            else if (in_ready)
                out_valid <= live;
            if (live) begin
                out_result     <= jump ? pc + size'(4) : S;
                out_rd         <= rd;
                out_reg_write  <= reg_write & !is_branch;
                out_mem_read   <= mem_read & !is_branch;
                out_mem_write  <= mem_write & !is_branch;
                out_store_data <= store_data;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (live & is_branch) begin
            if (branch_count != '1)
                branch_count <= branch_count + 32'd1;
            if (taken && taken_count != '1)
                taken_count <= taken_count + 32'd1;
        end
    end
`else
    assign branch_count = '0;
    assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// tb_ex_mem_branch_stage: randomized and directed checks against an operand-level model of the stage
module tb_ex_mem_branch_stage;

    localparam int W = 32;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, C, V, N, Z, reg_write, mem_read, mem_write;
    logic         is_branch, is_jal, is_jalr, flush, out_ready;
    logic [W-1:0] S, pc, imm, store_data;
    logic [4:0]   rd;
    logic [2:0]   br_type;
    logic         in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, redirect;
    logic [W-1:0] out_result, out_store_data, redirect_pc;
    logic [4:0]   out_rd;
    logic [31:0]  branch_count, taken_count;

    logic [W-1:0] a, b;
    int           n_cmp = 0;
    int           n_bad = 0;

    logic         m_valid, m_rw, m_mr, m_mw, m_redir;
    logic [W-1:0] m_result, m_sd, m_rpc;
    logic [4:0]   m_rd;
    int           m_sq;
    logic [31:0]  m_bc, m_tc;

    ex_mem_branch_stage #(.size(W), .SQUASH_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .S(S), .C(C), .V(V), .N(N), .Z(Z),
        .pc(pc), .imm(imm), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .store_data(store_data), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .br_type(br_type), .flush(flush),
        .out_ready(out_ready), .in_ready(in_ready), .out_valid(out_valid),
        .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // branch decision from the real operands, not from the flags
    function automatic logic model_taken(input logic [2:0] t, input logic [W-1:0] x, input logic [W-1:0] y);
        case (t)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) < $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            3'b110:  return x < y;
            3'b111:  return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    // the ALU computed A-B; derive its result and flags arithmetically
    task automatic set_op(input logic v, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic [W-1:0] pc_i, input logic [W-1:0] imm_i, input logic [2:0] bt,
                          input logic br, input logic jl, input logic jr, input logic fl, input logic rdy);
        a = a_i;
        b = b_i;
        S = a - b;
        Z = (S == '0);
        N = S[W-1];
        C = (a >= b);
        V = (a[W-1] != b[W-1]) && (S[W-1] != a[W-1]);
        in_valid = v; pc = pc_i; imm = imm_i; br_type = bt;
        is_branch = br; is_jal = jl; is_jalr = jr; flush = fl; out_ready = rdy;
        rd = 5'($urandom); reg_write = 1'($urandom); mem_read = 1'($urandom);
        mem_write = 1'($urandom); store_data = $urandom;
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_redir = 0;
        m_result = '0; m_sd = '0; m_rpc = '0; m_rd = '0; m_sq = 0; m_bc = '0; m_tc = '0;
    endtask

    task automatic model_step();
        logic acc, tk, jmp;
        acc = in_valid && (!m_valid || out_ready);
        jmp = is_jal || is_jalr;
        tk  = is_branch && model_taken(br_type, a, b);
        if (flush) begin
            m_valid = 0; m_redir = 0; m_sq = 0;
        end else begin
            m_redir = 0;
            if (acc && m_sq > 0) begin
                m_sq--;
                m_valid = 0;
            end else if (acc) begin
                m_valid  = 1;
                m_result = jmp ? pc + 32'd4 : a - b;
                m_rd = rd; m_sd = store_data;
                m_rw = reg_write && !is_branch;
                m_mr = mem_read && !is_branch;
                m_mw = mem_write && !is_branch;
                if (jmp || tk) begin
                    m_redir = 1;
                    m_rpc = is_jalr ? ((a - b) & ~32'd1) : pc + imm;
                    m_sq = D;
                end
                if (is_branch) begin
                    if (m_bc != 32'hFFFF_FFFF) m_bc++;
                    if (tk && m_tc != 32'hFFFF_FFFF) m_tc++;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("redirect", 32'(redirect), 32'(m_redir));
        if (m_valid) begin
            chk("out_result", out_result, m_result);
            chk("out_rd", 32'(out_rd), 32'(m_rd));
            chk("out_reg_write", 32'(out_reg_write), 32'(m_rw));
            chk("out_mem_read", 32'(out_mem_read), 32'(m_mr));
            chk("out_mem_write", 32'(out_mem_write), 32'(m_mw));
            chk("out_store_data", out_store_data, m_sd);
        end
        if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_STATS_EN
        chk("branch_count", branch_count, m_bc);
        chk("taken_count", taken_count, m_tc);
`else
        chk("branch_count", branch_count, 32'd0);
        chk("taken_count", taken_count, 32'd0);
`endif
    endtask

    task automatic cycle();
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_redirect"}, 32'(redirect), 32'd0);
        chk({tag, "_result"}, out_result, 32'd0);
        chk({tag, "_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_flags"}, 32'({out_reg_write, out_mem_read, out_mem_write}), 32'd0);
        chk({tag, "_store"}, out_store_data, 32'd0);
        chk({tag, "_rpc"}, redirect_pc, 32'd0);
        chk({tag, "_counts"}, branch_count | taken_count, 32'd0);
    endtask

    task automatic alu(input logic [W-1:0] x, input logic [W-1:0] y);
        set_op(1, x, y, 32'h200, 32'h8, 3'b010, 0, 0, 0, 0, 1);
        cycle();
    endtask

    initial begin
        logic [W-1:0] held;
        reset = 0;
        set_op(1, 32'h55, 32'h11, 32'h100, 32'h4, 3'b000, 1, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1;

        // taken BEQ redirects, squashes two, then resumes
        set_op(1, 32'd5, 32'd5, 32'h100, 32'h20, 3'b000, 1, 0, 0, 0, 1);
        cycle();
        chk("beq_redirect", 32'(redirect), 32'd1);
        chk("beq_rpc", redirect_pc, 32'h120);
        chk("beq_rw", 32'(out_reg_write), 32'd0);
        alu(32'd7, 32'd2);
        chk("sq1_valid", 32'(out_valid), 32'd0);
        chk("sq1_redirect", 32'(redirect), 32'd0);
        alu(32'd7, 32'd2);
        chk("sq2_valid", 32'(out_valid), 32'd0);
        alu(32'd30, 32'd8);
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_result", out_result, 32'h16);

        // BLTU with C=1 not taken, BGEU with C=1 taken
        set_op(1, 32'd9, 32'd3, 32'h300, 32'h40, 3'b110, 1, 0, 0, 0, 1);
        cycle();
        chk("bltu_redirect", 32'(redirect), 32'd0);
        alu(32'd4, 32'd1);
        chk("bltu_nosquash", 32'(out_valid), 32'd1);
        set_op(1, 32'd9, 32'd3, 32'h300, 32'h40, 3'b111, 1, 0, 0, 0, 1);
        cycle();
        chk("bgeu_redirect", 32'(redirect), 32'd1);
        chk("bgeu_rpc", redirect_pc, 32'h340);
        alu(32'd1, 32'd1);
        alu(32'd1, 32'd1);

        // JALR target clears bit 0, link is pc+4
        set_op(1, 32'h1003, 32'h0, 32'h40, 32'h0, 3'b000, 0, 0, 1, 0, 1);
        reg_write = 1;
        cycle();
        chk("jalr_rpc", redirect_pc, 32'h1002);
        chk("jalr_result", out_result, 32'h44);
        chk("jalr_rw", 32'(out_reg_write), 32'd1);
        alu(32'd1, 32'd1);
        alu(32'd1, 32'd1);

        // backpressure holds the output register
        alu(32'd100, 32'd1);
        held = out_result;
        repeat (3) begin
            set_op(1, 32'd77, 32'd7, 32'h0, 32'h0, 3'b010, 0, 0, 0, 0, 0);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            cycle();
            chk("stall_hold", out_result, held);
        end
        set_op(1, 32'd50, 32'd8, 32'h0, 32'h0, 3'b010, 0, 0, 0, 0, 1);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        cycle();
        chk("release_result", out_result, 32'd42);

        // flush kills a taken BNE
        set_op(1, 32'd1, 32'd2, 32'h500, 32'h10, 3'b001, 1, 0, 0, 1, 1);
        cycle();
        chk("flush_redirect", 32'(redirect), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        alu(32'd3, 32'd1);
        chk("flush_run", 32'(out_valid), 32'd1);

        // reset mid-squash aborts it
        set_op(1, 32'd6, 32'd6, 32'h600, 32'h8, 3'b000, 1, 0, 0, 0, 1);
        cycle();
        alu(32'd2, 32'd1);
        reset = 0;
        #1;
        chk_zero("midreset");
        model_reset();
        @(negedge clk);
        reset = 1;
        alu(32'd9, 32'd4);
        chk("post_reset_valid", 32'(out_valid), 32'd1);
        chk("post_reset_result", out_result, 32'd5);

        // randomized traffic
        repeat (3000) begin
            int kind;
            logic [W-1:0] ra;
            kind = $urandom_range(0, 3);
            ra = $urandom;
            set_op(1'($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 3) == 0) ? ra : $urandom,
                   $urandom, $urandom, 3'($urandom_range(0, 7)), kind == 1, kind == 2, kind == 3,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
